// File: rtl/axi_wr_arbiter.sv
// Round-robin write-path arbiter: grants one master a full AW -> W -> B transaction,
// drives the mux select/enables and checks the W beat count against the captured AWLEN.
module axi_wr_arbiter #(
    parameter  int INPUT_NUM = 3,
    localparam int IDX_W     = $clog2(INPUT_NUM)
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [INPUT_NUM-1:0] awvalid_i,
    input  logic [7:0]           awlen_i,
    input  logic                 aw_hs_i,
    input  logic                 w_hs_i,
    input  logic                 wlast_i,
    input  logic                 b_hs_i,
    output logic [INPUT_NUM-1:0] grant_o,
    output logic [IDX_W-1:0]     sel_o,
    output logic                 aw_en_o,
    output logic                 w_en_o,
    output logic                 b_en_o,
    output logic [7:0]           beat_cnt_o,
    output logic                 len_err_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] sel_reg, sel_next;
    logic [IDX_W-1:0] last_reg, last_next;
    logic [7:0]       len_reg, len_next;
    logic [8:0]       cnt_reg, cnt_next;
    logic [8:0]       cnt_inc;
    logic [8:0]       len_plus1;
    logic             err_reg, err_next;
    logic [IDX_W-1:0] pick;

    // Candidate gi is the master at offset gi+1 past the last winner (mod INPUT_NUM).
    logic [IDX_W:0]       cand_sum [INPUT_NUM];
    logic [IDX_W-1:0]     cand_idx [INPUT_NUM];
    logic [INPUT_NUM-1:0] req_rot;

    genvar gi;
    generate
        for (gi = 0; gi < INPUT_NUM; gi++) begin : g_rot
            assign cand_sum[gi] = {1'b0, last_reg} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(INPUT_NUM))
                                ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(INPUT_NUM))
                                : IDX_W'(cand_sum[gi]);
            assign req_rot[gi]  = awvalid_i[cand_idx[gi]];
        end
        for (gi = 0; gi < INPUT_NUM; gi++) begin : g_grant
            assign grant_o[gi] = (state_reg != IDLE) && (sel_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        pick = '0;
        for (int i = INPUT_NUM - 1; i >= 0; i--) begin
            if (req_rot[i]) pick = cand_idx[i];
        end
    end

    // Counter is one bit wider than the port so a 256-beat burst compares correctly.
    assign cnt_inc   = (cnt_reg == 9'h1FF) ? cnt_reg : cnt_reg + 9'd1;
    assign len_plus1 = {1'b0, len_reg} + 9'd1;

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        aw_en_o    = 1'b0;
        w_en_o     = 1'b0;
        b_en_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|awvalid_i) begin
                    sel_next   = pick;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                aw_en_o = 1'b1;
                if (aw_hs_i) begin
                    len_next   = awlen_i;
                    cnt_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                w_en_o = 1'b1;
                if (w_hs_i) begin
                    cnt_next = cnt_inc;
                    if (wlast_i) begin
                        err_next   = (cnt_inc != len_plus1);
                        state_next = RESP;
                    end else begin
                        err_next = (cnt_inc == len_plus1);
                    end
                end
            end
            RESP: begin
                b_en_o = 1'b1;
                if (b_hs_i) begin
                    last_next  = sel_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            last_reg  <= IDX_W'(INPUT_NUM - 1);
            len_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    assign sel_o      = sel_reg;
    assign beat_cnt_o = cnt_reg[8] ? 8'hFF : cnt_reg[7:0];
    assign len_err_o  = err_reg;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: stimulus pushes expected grants, error pulses
// and exit beat counts; a negedge monitor pops and compares as the DUT presents them.
module tb_axi_wr_arbiter;
    localparam int N = 3;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [N-1:0] awvalid = '0;
    logic [7:0]   awlen = '0;
    logic         aw_hs = 1'b0;
    logic         w_hs = 1'b0;
    logic         wlast = 1'b0;
    logic         b_hs = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   sel;
    logic         aw_en, w_en, b_en;
    logic [7:0]   beat_cnt;
    logic         len_err;

    axi_wr_arbiter #(.INPUT_NUM(N)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .awvalid_i(awvalid), .awlen_i(awlen),
        .aw_hs_i(aw_hs), .w_hs_i(w_hs), .wlast_i(wlast), .b_hs_i(b_hs),
        .grant_o(grant), .sel_o(sel), .aw_en_o(aw_en), .w_en_o(w_en), .b_en_o(b_en),
        .beat_cnt_o(beat_cnt), .len_err_o(len_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {int sel; int gap;} gexp_t;
    gexp_t q_grant[$];
    int    q_err[$];
    int    q_exit[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor
    int           cyc = 0;
    int           last_b_cyc = -100;
    logic [N-1:0] prev_grant = '0;
    gexp_t        g;
    int           e;

    always @(negedge ACLK) begin
        cyc++;
        if (ARESETn) begin
            chk("enable_excl", ($countones({aw_en, w_en, b_en}) <= 1), 1);
            if (grant != 0) begin
                chk("grant_onehot", grant, (1 << sel));
                if (prev_grant != 0) begin
                    chk("grant_stable", grant, prev_grant);
                end else if (q_grant.size() == 0) begin
                    chk("grant_unexpected", grant, 0);
                end else begin
                    g = q_grant.pop_front();
                    $display("grant: master %0d (expected %0d) gap=%0d", sel, g.sel, cyc - last_b_cyc - 1);
                    chk("grant_idx", sel, g.sel);
                    if (g.gap >= 0) chk("idle_gap", cyc - last_b_cyc - 1, g.gap);
                end
            end
            if (len_err) begin
                if (q_err.size() == 0) begin
                    chk("len_err_unexpected", len_err, 0);
                end else begin
                    e = q_err.pop_front();
                    chk("len_err_beat", beat_cnt, e);
                end
            end
            if (b_en && b_hs) begin
                last_b_cyc = cyc;
                if (q_exit.size() == 0) begin
                    chk("exit_unexpected", b_hs, 0);
                end else begin
                    e = q_exit.pop_front();
                    $display("resp: master %0d beats=%0d (expected %0d)", sel, beat_cnt, e);
                    chk("exit_beats", beat_cnt, e);
                end
            end
        end
        prev_grant = grant;
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_aw();
        int t = 0;
        while (!aw_en && t < 20) begin
            step();
            t++;
        end
        if (!aw_en) chk("aw_en_timeout", aw_en, 1);
    endtask

    task automatic run_txn(input logic [7:0] len, input int nbeats, input logic [N-1:0] clr);
        wait_aw();
        awlen = len;
        aw_hs = 1'b1;
        step();
        aw_hs = 1'b0;
        awvalid = awvalid & ~clr;
        for (int b = 1; b <= nbeats; b++) begin
            w_hs  = 1'b1;
            wlast = (b == nbeats);
            step();
        end
        w_hs  = 1'b0;
        wlast = 1'b0;
        b_hs  = 1'b1;
        step();
        b_hs  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_aw_en"}, aw_en, 0);
        chk({tag, "_w_en"}, w_en, 0);
        chk({tag, "_b_en"}, b_en, 0);
        chk({tag, "_beat_cnt"}, beat_cnt, 0);
        chk({tag, "_len_err"}, len_err, 0);
    endtask

    initial begin
        repeat (2) step();
        chk_reset("rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        step();

        // All three request, AWLEN=0: order 0,1,2,0 with one idle cycle between
        awvalid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            q_grant.push_back('{k % 3, (k == 0) ? -1 : 1});
            q_exit.push_back(1);
            run_txn(8'd0, 1, 3'b000);
        end

        // Master 1 only, AWLEN=3, 4 beats
        awvalid = 3'b010;
        q_grant.push_back('{1, 1});
        q_exit.push_back(4);
        run_txn(8'd3, 4, 3'b010);

        // Early WLAST: AWLEN=3, WLAST on beat 2
        awvalid = 3'b100;
        q_grant.push_back('{2, 1});
        q_err.push_back(2);
        q_exit.push_back(2);
        run_txn(8'd3, 2, 3'b100);

        // Late WLAST: AWLEN=1, WLAST on beat 3 (error at count reach and at WLAST)
        awvalid = 3'b001;
        q_grant.push_back('{0, 1});
        q_err.push_back(2);
        q_err.push_back(3);
        q_exit.push_back(3);
        run_txn(8'd1, 3, 3'b001);

        // Asynchronous reset in the middle of a 4-beat burst
        awvalid = 3'b111;
        q_grant.push_back('{1, 1});
        wait_aw();
        awlen = 8'd3;
        aw_hs = 1'b1;
        step();
        aw_hs = 1'b0;
        w_hs  = 1'b1;
        step();
        step();
        w_hs  = 1'b0;
        chk("beats_before_rst", beat_cnt, 2);
        #2;
        ARESETn = 1'b0;
        #1;
        chk_reset("async_rst");
        step();
        step();
        @(negedge ACLK);
        ARESETn = 1'b1;

        // After reset master 0 wins the tie; stray W/B handshakes in ADDR are ignored
        q_grant.push_back('{0, -1});
        wait_aw();
        w_hs = 1'b1;
        b_hs = 1'b1;
        step();
        w_hs = 1'b0;
        b_hs = 1'b0;
        chk("addr_ignore_beat_cnt", beat_cnt, 0);
        chk("addr_ignore_w_en", w_en, 0);
        chk("addr_ignore_b_en", b_en, 0);
        chk("addr_still_aw_en", aw_en, 1);
        q_exit.push_back(1);
        run_txn(8'd0, 1, 3'b111);

        awvalid = '0;
        repeat (4) step();
        chk("grant_q_left", q_grant.size(), 0);
        chk("err_q_left", q_err.size(), 0);
        chk("exit_q_left", q_exit.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
